// File: rtl/uart_transmitter.sv
// uart_transmitter: byte-wide valid/ready input, serial frame output.
// Frame is one start bit (0), eight data bits LSB first, then one or two
// stop bits (1). Each bit lasts CLKS_PER_BIT cycles. One byte in flight.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line high, in_ready high, waiting for in_valid
// START | start bit, line low for one bit period
// DATA  | eight data bits from the shift register, LSB first
// STOP  | stop bit(s), line high; done pulses in the final cycle
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_out,
    output logic       busy,
    output logic       done
);

    // Bit-period counter is at least one bit wide so CLKS_PER_BIT=1 still
    // has a legal vector; with one clock per bit it simply stays at zero.
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic          stop_cnt;
    logic          stop_cnt_d;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_d;
    logic          data_out_d;
    logic          bit_end;

    // Handshake flags decode straight from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    // Next-state, datapath updates and the done pulse.
    always_comb begin
        state_d    = state;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        shift_d    = shift_reg;
        done       = 1'b0;
        bit_end    = (bit_cnt == BIT_LAST);

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d    = START;
                    shift_d    = in;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                        done       = 1'b1;
                    end else begin
                        stop_cnt_d = ~stop_cnt;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts at every bit boundary and on every state change.
        if ((state_d != state) || bit_end || (state == IDLE)) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt + CW'(1);
        end

        // Line value for the next cycle, so data_out leaves a flop.
        unique case (state_d)
            START:   data_out_d = 1'b0;
            DATA:    data_out_d = shift_d[0];
            default: data_out_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered serial line.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            stop_cnt  <= 1'b0;
            shift_reg <= 8'h00;
            data_out  <= 1'b1;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            bit_idx   <= bit_idx_d;
            stop_cnt  <= stop_cnt_d;
            shift_reg <= shift_d;
            data_out  <= data_out_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four instances with different bit periods and
// stop-bit counts, each frame compared cycle by cycle against a frame model.
module tb_uart_transmitter;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] in_v [4];
    logic [3:0] valid_v;
    logic [3:0] line_v;
    logic [3:0] rdy_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_line [0:127];
    logic cap_busy [0:127];
    logic cap_done [0:127];
    logic cap_rdy  [0:127];

    always #5 clk_in = ~clk_in;

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_c4 (
        .clk_in(clk_in), .reset(reset), .in(in_v[0]), .in_valid(valid_v[0]),
        .in_ready(rdy_v[0]), .data_out(line_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_c1 (
        .clk_in(clk_in), .reset(reset), .in(in_v[1]), .in_valid(valid_v[1]),
        .in_ready(rdy_v[1]), .data_out(line_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_transmitter #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_c2 (
        .clk_in(clk_in), .reset(reset), .in(in_v[2]), .in_valid(valid_v[2]),
        .in_ready(rdy_v[2]), .data_out(line_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_c3 (
        .clk_in(clk_in), .reset(reset), .in(in_v[3]), .in_valid(valid_v[3]),
        .in_ready(rdy_v[3]), .data_out(line_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // Expected line level t cycles after the acceptance edge (t=1 is the
    // first cycle of the start bit); outside the frame the line idles high.
    function automatic logic model_line(input logic [7:0] b, input int c, input int s, input int t);
        int slot;
        if (t < 1 || t > (9 + s) * c) return 1'b1;
        slot = (t - 1) / c;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[3'(slot - 1)];
        return 1'b1;
    endfunction

    // Present a byte at a falling edge and return right at the accepting edge.
    task automatic wait_accept(input int k, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk_in);
        in_v[k]    = b;
        valid_v[k] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rdy_v[k]) begin
                @(posedge clk_in);
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic capture(input int k, input int n);
        for (int t = 1; t <= n; t++) begin
            @(negedge clk_in);
            cap_line[t] = line_v[k];
            cap_busy[t] = busy_v[k];
            cap_done[t] = done_v[k];
            cap_rdy[t]  = rdy_v[k];
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            valid_v = 4'($urandom);
            for (int j = 0; j < 4; j++) in_v[j] = 8'($urandom);
            #1;
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if ({line_v[j], rdy_v[j], busy_v[j], done_v[j]} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL reset_hold inst=%0d: got line/rdy/busy/done=%b expected 1100",
                             j, {line_v[j], rdy_v[j], busy_v[j], done_v[j]});
                end
            end
        end
        valid_v = 4'b0000;
        @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if ({line_v[j], rdy_v[j], busy_v[j], done_v[j]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_release inst=%0d: got %b expected 1100",
                         j, {line_v[j], rdy_v[j], busy_v[j], done_v[j]});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        bit         ok;
        int         f;
        f = 40;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'hA5 : 8'($urandom);
            wait_accept(0, b, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL single_accept: in_ready never high, expected acceptance");
                valid_v[0] = 1'b0;
                continue;
            end
            #1;
            valid_v[0] = 1'b0;
            in_v[0]    = ~b;
            capture(0, f + 1);
            for (int t = 1; t <= f + 1; t++) begin
                n_checks++;
                if (cap_line[t] !== model_line(b, 4, 1, t)) begin
                    n_fail++;
                    $display("FAIL single_line byte=%h t=%0d: got %b expected %b", b, t, cap_line[t], model_line(b, 4, 1, t));
                end
                n_checks++;
                if (cap_busy[t] !== (t <= f)) begin
                    n_fail++;
                    $display("FAIL single_busy byte=%h t=%0d: got %b expected %b", b, t, cap_busy[t], (t <= f));
                end
                n_checks++;
                if (cap_done[t] !== (t == f)) begin
                    n_fail++;
                    $display("FAIL single_done byte=%h t=%0d: got %b expected %b", b, t, cap_done[t], (t == f));
                end
                n_checks++;
                if (cap_rdy[t] !== (t == f + 1)) begin
                    n_fail++;
                    $display("FAIL single_ready byte=%h t=%0d: got %b expected %b", b, t, cap_rdy[t], (t == f + 1));
                end
            end
        end
    endtask

    // in_valid stays high across both frames; second acceptance happens in
    // the single idle cycle between them.
    task automatic test_back_to_back();
        bit   ok;
        logic el;
        logic eb;
        wait_accept(1, 8'h00, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_accept: in_ready never high, expected acceptance");
        end
        #1;
        in_v[1] = 8'hFF;
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk_in);
            if (t <= 10)      el = model_line(8'h00, 1, 1, t);
            else if (t == 11) el = 1'b1;
            else if (t <= 21) el = model_line(8'hFF, 1, 1, t - 11);
            else              el = 1'b1;
            eb = (t <= 10) || (t >= 12 && t <= 21);
            n_checks++;
            if (line_v[1] !== el) begin
                n_fail++;
                $display("FAIL b2b_line t=%0d: got %b expected %b", t, line_v[1], el);
            end
            n_checks++;
            if (busy_v[1] !== eb || rdy_v[1] !== ~eb) begin
                n_fail++;
                $display("FAIL b2b_busy_ready t=%0d: got busy=%b ready=%b expected busy=%b", t, busy_v[1], rdy_v[1], eb);
            end
            n_checks++;
            if (done_v[1] !== (t == 10 || t == 21)) begin
                n_fail++;
                $display("FAIL b2b_done t=%0d: got %b expected %b", t, done_v[1], (t == 10 || t == 21));
            end
            if (t == 11) begin
                @(posedge clk_in);
                #1;
                valid_v[1] = 1'b0;
            end
        end
    endtask

    task automatic test_ignore_busy();
        bit   ok;
        logic el;
        logic eb;
        wait_accept(2, 8'h3C, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_accept: in_ready never high, expected acceptance");
        end
        for (int t = 1; t <= 42; t++) begin
            @(negedge clk_in);
            if (t <= 20)      el = model_line(8'h3C, 2, 1, t);
            else if (t == 21) el = 1'b1;
            else if (t <= 41) el = model_line(8'hC3, 2, 1, t - 21);
            else              el = 1'b1;
            eb = (t <= 20) || (t >= 22 && t <= 41);
            n_checks++;
            if (line_v[2] !== el) begin
                n_fail++;
                $display("FAIL ignore_line t=%0d: got %b expected %b", t, line_v[2], el);
            end
            n_checks++;
            if (rdy_v[2] !== ~eb || busy_v[2] !== eb) begin
                n_fail++;
                $display("FAIL ignore_ready t=%0d: got ready=%b busy=%b expected ready=%b", t, rdy_v[2], busy_v[2], ~eb);
            end
            if (t == 7) in_v[2] = 8'hC3;
            if (t == 21) begin
                @(posedge clk_in);
                #1;
                valid_v[2] = 1'b0;
            end
        end
    endtask

    task automatic test_two_stop();
        logic [7:0] b;
        bit         ok;
        int         f;
        f = 33;
        for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'h81 : 8'($urandom);
            wait_accept(3, b, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL stop2_accept: in_ready never high, expected acceptance");
                valid_v[3] = 1'b0;
                continue;
            end
            #1;
            valid_v[3] = 1'b0;
            in_v[3]    = 8'($urandom);
            capture(3, f + 1);
            for (int t = 1; t <= f + 1; t++) begin
                n_checks++;
                if (cap_line[t] !== model_line(b, 3, 2, t)) begin
                    n_fail++;
                    $display("FAIL stop2_line byte=%h t=%0d: got %b expected %b", b, t, cap_line[t], model_line(b, 3, 2, t));
                end
                n_checks++;
                if (cap_busy[t] !== (t <= f) || cap_rdy[t] !== (t > f)) begin
                    n_fail++;
                    $display("FAIL stop2_busy byte=%h t=%0d: got busy=%b ready=%b expected busy=%b", b, t, cap_busy[t], cap_rdy[t], (t <= f));
                end
                n_checks++;
                if (cap_done[t] !== (t == f)) begin
                    n_fail++;
                    $display("FAIL stop2_done byte=%h t=%0d: got %b expected %b", b, t, cap_done[t], (t == f));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_accept(0, 8'h55, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_accept: in_ready never high, expected acceptance");
        end
        #1;
        valid_v[0] = 1'b0;
        // Data bit 3 spans t=17..20 with four clocks per bit.
        repeat (18) @(negedge clk_in);
        n_checks++;
        if (line_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_before: got line=%b busy=%b expected line=0 busy=1", line_v[0], busy_v[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({line_v[0], rdy_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL rstmid_async: got line/rdy/busy/done=%b expected 1100",
                     {line_v[0], rdy_v[0], busy_v[0], done_v[0]});
        end
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        wait_accept(0, 8'h0F, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_reaccept: in_ready never high, expected acceptance");
        end
        #1;
        valid_v[0] = 1'b0;
        capture(0, 41);
        for (int t = 1; t <= 41; t++) begin
            n_checks++;
            if (cap_line[t] !== model_line(8'h0F, 4, 1, t) || cap_done[t] !== (t == 40)) begin
                n_fail++;
                $display("FAIL rstmid_frame t=%0d: got line=%b done=%b expected line=%b done=%b",
                         t, cap_line[t], cap_done[t], model_line(8'h0F, 4, 1, t), (t == 40));
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 4; j++) in_v[j] = 8'h00;
        valid_v = 4'b0000;
        reset   = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_busy();
        test_two_stop();
        test_reset_mid();
        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
